alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Initiator-side companion to the 4-bit combinational `alu`: accepts operation commands over a valid/ready stream and buffers them in a small FIFO. It drives each command onto the ALU operand/select ports, waits a fixed settle time, then captures `y`/`carry`. Each captured result is compared against an internal golden model and returned on a valid/ready response stream, with a saturating mismatch counter. It sits between a command source (CPU-side sequencer or bench driver) and the `alu` instance.

## Interface
- `WIDTH`, 4, operand/result width; must match the `alu`.
- `DEPTH`, 4, command FIFO entries; power of two, ≥2.
- `SETTLE`, 1, cycles the ALU inputs are held before capture; ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; equals !full, registered, no combinational path from `rsp_ready`.
- `cmd_sel`  in  3  opcode.
- `cmd_a`, `cmd_b`  in  WIDTH  operands.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_sel`  out  3  registered opcode to the ALU.
- `alu_y`  in  WIDTH  ALU result.
- `alu_carry`  in  1  ALU carry.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_sel`  out  3  opcode of the response.
- `rsp_y`  out  WIDTH  captured `alu_y`.
- `rsp_carry`  out  1  captured `alu_carry`.
- `rsp_mismatch`  out  1  captured {y,carry} ≠ golden model.
- `err_count`  out  8  saturating mismatch count.
- `busy`  out  1  high when state ≠ IDLE or FIFO not empty.

## Operation
- Golden model, all results mod 2^WIDTH:
  - 000 ADD: y=a+b; carry=carry-out.
  - 001 SUB: y=a−b; carry=borrow (a<b).
  - 010 AND, 011 OR, 100 XOR, 101 XNOR: carry=0.
  - 110 SHL: y=a<<1; carry=a[WIDTH-1].
  - 111 SHR: y=a>>1; carry=a[0].
  - `b` is ignored for shifts.
- FIFO push on `cmd_valid && cmd_ready`. Push and pop in the same cycle are both honoured; occupancy is unchanged. No push when full; `cmd_ready` is low.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, load `alu_a/alu_b/alu_sel`, load the settle counter with SETTLE, go to DRIVE. Otherwise stay.
  - DRIVE: decrement the counter each cycle. In the cycle where the counter is 1, the next edge:
    - registers `rsp_y=alu_y`, `rsp_carry=alu_carry`, `rsp_sel=alu_sel`, and `rsp_mismatch` (golden model of the held `alu_*` vs captured values);
    - sets `rsp_valid=1`;
    - increments `err_count` on mismatch (saturates at 255);
    - goes to RESPOND.
  - RESPOND: all `rsp_*` held stable while `rsp_valid && !rsp_ready`. On handshake, clear `rsp_valid` and go to IDLE.
- `alu_*` outputs hold their last value between commands.
- Reset (any time, including mid-DRIVE or mid-RESPOND):
  - FIFO emptied; in-flight command dropped.
  - State = IDLE; `cmd_ready=1`; `rsp_valid=0`.
  - `alu_a/alu_b/alu_sel/rsp_y/rsp_carry/rsp_sel/rsp_mismatch=0`; `err_count=0`; `busy=0`.

## Timing
- Command accepted at edge E into an empty FIFO with FSM in IDLE:
  - `alu_*` update at E+1.
  - `rsp_valid` rises at E+1+SETTLE.
- With `rsp_ready` held high, the response handshake occurs at edge E+2+SETTLE.
- Back-to-back throughput: one command per SETTLE+2 cycles.
- `cmd_ready` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the pop that frees an entry.
- `err_count` updates on the same edge as `rsp_valid` rises.

## Structure
- Package `alu_pkg`:
  - `ALU_W` constant.
  - `alu_op_e` enum: ADD, SUB, AND, OR, XOR, XNOR, SHL, SHR = 000..111.
  - Function `alu_ref(a, b, sel)` returning {carry, y}; shared with the bench scoreboard.
- Sub-module `alu_cmd_fifo`:
  - synchronous FIFO of {sel,a,b};
  - ptr-plus-extra-bit full/empty;
  - `push/pop/full/empty` ports.
- FSM state enum is local to `alu_cmd_issuer`.

## Test plan
- Single ADD, a=3, b=2, SETTLE=1, `rsp_ready=1` -> `rsp_valid` at E+2; rsp_y=5, carry=0, mismatch=0.
- Overflow and borrow:
  - ADD 9+8 -> y=1, carry=1.
  - SUB 2−5 -> y=13, carry=1.
  - SHL 1001 -> y=0010, carry=1.
  - SHR 1000 -> y=0100, carry=0.
  - All with mismatch=0.
- Fill/backpressure: push 5 commands with `rsp_ready=0` -> `cmd_ready` low after the 4th push is queued and 1 is in flight. `rsp_*` held stable. Releasing `rsp_ready` returns all 5 responses in order with no loss.
- Fault injection: bench forces `alu_y` to 0 for XOR 1100^1010 -> rsp_mismatch=1, err_count=1. Forcing 300 mismatches -> err_count saturates at 255.
- Reset mid-DRIVE with 3 queued -> all outputs take reset values, `busy=0`, no response emitted. Operation resumes correctly on the next command.
- Simultaneous push/pop: push on the same edge IDLE pops, with occupancy 2 -> occupancy stays 2 and order is preserved.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and the golden ALU model used by the issuer and its bench.
package alu_pkg;

  localparam int unsigned ALU_W = 4;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    AND  = 3'b010,
    OR   = 3'b011,
    XOR  = 3'b100,
    XNOR = 3'b101,
    SHL  = 3'b110,
    SHR  = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e          sel;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_cmd_t;

  // Returns {carry, y}; carry is borrow for SUB and the shifted-out bit for shifts.
  function automatic logic [ALU_W:0] alu_ref(input logic [ALU_W-1:0] a,
                                             input logic [ALU_W-1:0] b,
                                             input alu_op_e          sel);
    logic [ALU_W:0] r;
    r = '0;
    case (sel)
      ADD:     r = {1'b0, a} + {1'b0, b};
      SUB:     r = {1'b0, a} - {1'b0, b};
      AND:     r = {1'b0, a & b};
      OR:      r = {1'b0, a | b};
      XOR:     r = {1'b0, a ^ b};
      XNOR:    r = {1'b0, ~(a ^ b)};
      SHL:     r = {a, 1'b0};
      SHR:     r = {a[0], 1'b0, a[ALU_W-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-drive and response signals of the ALU command issuer.
interface alu_cmd_issuer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_y;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_sel;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_carry;
  logic             rsp_mismatch;
  logic [7:0]       err_count;
  logic             busy;

  modport master (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, alu_y, alu_carry, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_sel, rsp_y,
           rsp_carry, rsp_mismatch, err_count, busy
  );

  modport slave (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, alu_y, alu_carry, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_sel, rsp_y,
           rsp_carry, rsp_mismatch, err_count, busy
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; full/empty registered, pointers carry a wrap bit.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  alu_cmd_t wdata_i,
  input  logic     pop_i,
  output alu_cmd_t rdata_c_o,
  output logic     full_o,
  output logic     empty_o,
  output logic     empty_nxt_c_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  alu_cmd_t      mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
    empty_d = (wr_d == rd_d);
    full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_c_o     = mem_q[rd_q[AW-1:0]];
  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign empty_nxt_c_o = empty_d;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues queued commands to an external ALU, captures results after a settle
// time and returns them with a golden-model mismatch flag and error count.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = ALU_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input logic            clk,
  input logic            rst_n,
  alu_cmd_issuer_if.master bus
);
  localparam int unsigned CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_RESPOND} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_y_q, rsp_y_d;
  logic [2:0]       alu_sel_q, alu_sel_d, rsp_sel_q, rsp_sel_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d;
  logic             rsp_mism_q, rsp_mism_d, busy_q, busy_d;
  logic [7:0]       err_q, err_d;

  alu_cmd_t         cmd_c, head_c;
  logic             push_c, pop_c, full, empty, empty_nxt_c;
  logic [ALU_W:0]   gold_c;
  logic             mism_c;

  assign cmd_c  = {alu_op_e'(bus.cmd_sel), ALU_W'(bus.cmd_a), ALU_W'(bus.cmd_b)};
  assign push_c = bus.cmd_valid && !full;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (push_c),
    .wdata_i       (cmd_c),
    .pop_i         (pop_c),
    .rdata_c_o     (head_c),
    .full_o        (full),
    .empty_o       (empty),
    .empty_nxt_c_o (empty_nxt_c)
  );

  // Golden result of the operands currently held on the ALU inputs.
  assign gold_c = alu_ref(ALU_W'(alu_a_q), ALU_W'(alu_b_q), alu_op_e'(alu_sel_q));
  assign mism_c = (gold_c != {bus.alu_carry, ALU_W'(bus.alu_y)});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sel_d   = rsp_sel_q;
    rsp_y_d     = rsp_y_q;
    rsp_carry_d = rsp_carry_q;
    rsp_mism_d  = rsp_mism_q;
    err_d       = err_q;
    pop_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop_c     = 1'b1;
          alu_a_d   = WIDTH'(head_c.a);
          alu_b_d   = WIDTH'(head_c.b);
          alu_sel_d = 3'(head_c.sel);
          cnt_d     = CW'(SETTLE);
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rsp_y_d     = bus.alu_y;
          rsp_carry_d = bus.alu_carry;
          rsp_sel_d   = alu_sel_q;
          rsp_mism_d  = mism_c;
          rsp_valid_d = 1'b1;
          if (mism_c && (err_q != 8'hFF)) err_d = err_q + 8'd1;
          state_d     = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) || !empty_nxt_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sel_q   <= '0;
      rsp_y_q     <= '0;
      rsp_carry_q <= 1'b0;
      rsp_mism_q  <= 1'b0;
      err_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sel_q   <= rsp_sel_d;
      rsp_y_q     <= rsp_y_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_mism_q  <= rsp_mism_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready    = !full;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_sel      = alu_sel_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_sel      = rsp_sel_q;
  assign bus.rsp_y        = rsp_y_q;
  assign bus.rsp_carry    = rsp_carry_q;
  assign bus.rsp_mismatch = rsp_mism_q;
  assign bus.err_count    = err_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer; the bench plays the 4-bit ALU itself.
module tb_alu_cmd_issuer;

  logic clk = 1'b0;
  logic rst_n;
  logic fault;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.WIDTH(4)) bus ();

  alu_cmd_issuer #(.WIDTH(4), .DEPTH(4), .SETTLE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Independent behavioural ALU; fault forces y to zero.
  logic [3:0] m_y;
  logic       m_c;
  always_comb begin
    m_y = '0;
    m_c = 1'b0;
    case (bus.alu_sel)
      3'd0: {m_c, m_y} = 5'(bus.alu_a) + 5'(bus.alu_b);
      3'd1: begin m_y = bus.alu_a - bus.alu_b; m_c = (bus.alu_a < bus.alu_b); end
      3'd2: m_y = bus.alu_a & bus.alu_b;
      3'd3: m_y = bus.alu_a | bus.alu_b;
      3'd4: m_y = bus.alu_a ^ bus.alu_b;
      3'd5: m_y = ~(bus.alu_a ^ bus.alu_b);
      3'd6: begin m_y = {bus.alu_a[2:0], 1'b0}; m_c = bus.alu_a[3]; end
      default: begin m_y = {1'b0, bus.alu_a[3:1]}; m_c = bus.alu_a[0]; end
    endcase
  end
  assign bus.alu_y     = fault ? 4'd0 : m_y;
  assign bus.alu_carry = m_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b);
    int i;
    i = 0;
    while (!bus.cmd_ready && i < 50) begin step(); i++; end
    if (!bus.cmd_ready) chk("cmd_ready_timeout", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int i;
    i = 0;
    while (!bus.rsp_valid && i < 30) begin step(); i++; end
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 1);
  endtask

  // Waits for a response, checks it, then lets the handshake edge pass.
  task automatic collect(input string tag, input logic [2:0] sel, input logic [3:0] y,
                         input logic c, input logic m);
    bus.rsp_ready = 1'b1;
    wait_rsp(tag);
    chk({tag, "_sel"}, 32'(bus.rsp_sel), 32'(sel));
    chk({tag, "_y"}, 32'(bus.rsp_y), 32'(y));
    chk({tag, "_carry"}, 32'(bus.rsp_carry), 32'(c));
    chk({tag, "_mism"}, 32'(bus.rsp_mismatch), 32'(m));
    step();
  endtask

  task automatic quiet_run(input int n);
    for (int k = 0; k < n; k++) begin
      push_cmd(3'd4, 4'b1100, 4'b1010);
      for (int i = 0; i < 30 && !bus.rsp_valid; i++) step();
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fault = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err_count), 0);
    chk("rst_alu_a", 32'(bus.alu_a), 0);
    chk("rst_rsp_y", 32'(bus.rsp_y), 0);
    rst_n = 1'b1;
    step();

    // Single ADD 3+2 with exact latency.
    bus.rsp_ready = 1'b1;
    push_cmd(3'd0, 4'd3, 4'd2);
    chk("add_busy_e", 32'(bus.busy), 1);
    chk("add_alu_a_e", 32'(bus.alu_a), 0);
    step();
    chk("add_alu_a", 32'(bus.alu_a), 3);
    chk("add_alu_b", 32'(bus.alu_b), 2);
    chk("add_alu_sel", 32'(bus.alu_sel), 0);
    chk("add_valid_e1", 32'(bus.rsp_valid), 0);
    step();
    chk("add_valid_e2", 32'(bus.rsp_valid), 1);
    chk("add_y", 32'(bus.rsp_y), 5);
    chk("add_carry", 32'(bus.rsp_carry), 0);
    chk("add_mism", 32'(bus.rsp_mismatch), 0);
    step();
    chk("add_valid_e3", 32'(bus.rsp_valid), 0);
    chk("add_busy_e3", 32'(bus.busy), 0);

    // Overflow, borrow, shifts and logic ops.
    push_cmd(3'd0, 4'd9, 4'd8);         collect("add_ovf", 3'd0, 4'd1, 1'b1, 1'b0);
    push_cmd(3'd1, 4'd2, 4'd5);         collect("sub_brw", 3'd1, 4'd13, 1'b1, 1'b0);
    push_cmd(3'd6, 4'b1001, 4'd0);      collect("shl", 3'd6, 4'b0010, 1'b1, 1'b0);
    push_cmd(3'd7, 4'b1000, 4'd0);      collect("shr", 3'd7, 4'b0100, 1'b0, 1'b0);
    push_cmd(3'd2, 4'b1100, 4'b1010);   collect("and", 3'd2, 4'b1000, 1'b0, 1'b0);
    push_cmd(3'd3, 4'b1100, 4'b1010);   collect("or", 3'd3, 4'b1110, 1'b0, 1'b0);
    push_cmd(3'd5, 4'b1100, 4'b1010);   collect("xnor", 3'd5, 4'b1001, 1'b0, 1'b0);
    chk("err_clean", 32'(bus.err_count), 0);

    // Fill and backpressure: five commands, responses held.
    bus.rsp_ready = 1'b0;
    push_cmd(3'd0, 4'd1, 4'd1);
    push_cmd(3'd1, 4'd7, 4'd3);
    push_cmd(3'd3, 4'b0101, 4'b0010);
    push_cmd(3'd2, 4'b1111, 4'b0011);
    push_cmd(3'd4, 4'b1111, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("bp_hold_valid", 32'(bus.rsp_valid), 1);
      chk("bp_hold_y", 32'(bus.rsp_y), 2);
      step();
    end
    collect("bp0", 3'd0, 4'd2, 1'b0, 1'b0);
    collect("bp1", 3'd1, 4'd4, 1'b0, 1'b0);
    collect("bp2", 3'd3, 4'd7, 1'b0, 1'b0);
    collect("bp3", 3'd2, 4'd3, 1'b0, 1'b0);
    collect("bp4", 3'd4, 4'd14, 1'b0, 1'b0);
    chk("bp_ready_back", 32'(bus.cmd_ready), 1);
    chk("bp_busy_done", 32'(bus.busy), 0);

    // Simultaneous push and pop at occupancy 2.
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_cmd(3'd0, 4'(k + 1), 4'd2);
    chk("pp_held_y", 32'(bus.rsp_y), 3);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    push_cmd(3'd0, 4'd4, 4'd2);
    push_cmd(3'd0, 4'd5, 4'd2);
    chk("pp_ready_occ3", 32'(bus.cmd_ready), 1);
    push_cmd(3'd0, 4'd6, 4'd2);
    chk("pp_full_occ4", 32'(bus.cmd_ready), 0);
    for (int k = 0; k < 5; k++) collect("pp", 3'd0, 4'(k + 4), 1'b0, 1'b0);

    // Fault injection and saturation.
    fault = 1'b1;
    push_cmd(3'd4, 4'b1100, 4'b1010);
    collect("flt", 3'd4, 4'd0, 1'b0, 1'b1);
    chk("flt_err1", 32'(bus.err_count), 1);
    quiet_run(253);
    chk("flt_err254", 32'(bus.err_count), 254);
    quiet_run(1);
    chk("flt_err255", 32'(bus.err_count), 255);
    quiet_run(46);
    chk("flt_sat", 32'(bus.err_count), 255);
    fault = 1'b0;
    push_cmd(3'd0, 4'd6, 4'd7);
    collect("flt_off", 3'd0, 4'd13, 1'b0, 1'b0);
    chk("flt_sat_hold", 32'(bus.err_count), 255);

    // Reset mid-DRIVE with three commands queued.
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_cmd(3'd0, 4'(k), 4'd1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    push_cmd(3'd0, 4'd9, 4'd1);
    chk("mid_alu_a", 32'(bus.alu_a), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mr_busy", 32'(bus.busy), 0);
    chk("mr_err", 32'(bus.err_count), 0);
    chk("mr_alu_a", 32'(bus.alu_a), 0);
    chk("mr_alu_sel", 32'(bus.alu_sel), 0);
    chk("mr_rsp_y", 32'(bus.rsp_y), 0);
    chk("mr_rsp_mism", 32'(bus.rsp_mismatch), 0);
    step();
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("mr_no_rsp", 32'(bus.rsp_valid), 0);
      chk("mr_idle", 32'(bus.busy), 0);
      step();
    end
    push_cmd(3'd0, 4'd3, 4'd4);
    collect("resume", 3'd0, 4'd7, 1'b0, 1'b0);
    chk("resume_err", 32'(bus.err_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
